// File: rtl/pe_3x3.sv
// pe_3x3 -- row processing element of the 3x3 convolution array.
//
// Holds one feature-map row (INPUT_NUM pixels) and one kernel row
// (WEIGHT_NUM taps), all signed fixed point Q(IW).(FW). Every clock it emits
// OUTPUT_NUM adjacent 1-D convolution results for the current group of
// windows. A group pointer then advances and wraps, so one row is swept
// continuously with no idle cycle. With config_i = 1, the partial sums of the
// two neighbouring kernel-row PEs are added in, so three instances together
// form a full 3x3 kernel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH (1 = reset) despite the name
//   fmap_i     INPUT_NUM*W bits, pixel i at [i*W +: W]
//   wht_i      WEIGHT_NUM*W bits, tap j at [j*W +: W]
//   array_i_0  neighbour partial sum 0 (W bits, signed)
//   array_i_1  neighbour partial sum 1 (W bits, signed)
//   config_i   0 = standalone, 1 = add array_i_0 + array_i_1
//   res_o      OUTPUT_NUM*W bits, result k at [k*W +: W], registered
//
// Interface timing: there is no valid/ready handshake. All inputs are sampled
// at the same edge that updates res_o (latency 1). res_o is valid every cycle
// after the first edge that follows reset release. That first edge outputs
// group 0.
//
// Build option: define PE3X3_SAT_EN to clamp each result to the W-bit signed
// range. When it is undefined, results wrap in two's complement.
module pe_3x3 #(
    parameter int INPUT_NUM  = 56,
    parameter int OUTPUT_NUM = 9,
    parameter int WEIGHT_NUM = 3,
    parameter int IW         = 24,
    parameter int FW         = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INPUT_NUM*(IW+FW)-1:0]      fmap_i,
    input  logic [WEIGHT_NUM*(IW+FW)-1:0]     wht_i,
    input  logic signed [IW+FW-1:0]           array_i_0,
    input  logic signed [IW+FW-1:0]           array_i_1,
    input  logic                              config_i,
    output logic [OUTPUT_NUM*(IW+FW)-1:0]     res_o
);

    localparam int W    = IW + FW;
    localparam int W1   = W + 1;
    localparam int NWIN = INPUT_NUM - WEIGHT_NUM + 1;
    localparam int NGRP = NWIN / OUTPUT_NUM;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    // Accumulator headroom: full products plus growth from summing the taps.
    localparam int AW   = 2 * W + $clog2(WEIGHT_NUM) + 2;
    localparam int IXW  = $clog2(INPUT_NUM * W);

    generate
        if ((NWIN % OUTPUT_NUM) != 0 || NWIN < OUTPUT_NUM) begin : g_bad_params
            $error("pe_3x3: INPUT_NUM-WEIGHT_NUM+1 must be a nonzero multiple of OUTPUT_NUM");
        end
    endgenerate

    logic [GW-1:0]               g;
    logic signed [W1-1:0]        bias;
    logic [IXW-1:0]              idx;
    logic signed [W-1:0]         px;
    logic signed [W-1:0]         tap;
    logic signed [2*W-1:0]       prod;
    logic signed [AW-1:0]        acc;
    logic [OUTPUT_NUM*W-1:0]     res_next;
`ifdef PE3X3_SAT_EN
    logic signed [AW-1:0]        sum;
`endif

    always_comb begin
        bias     = '0;
        idx      = '0;
        px       = '0;
        tap      = '0;
        prod     = '0;
        acc      = '0;
        res_next = '0;
`ifdef PE3X3_SAT_EN
        sum      = '0;
`endif
        // Bias is formed at W+1 bits, so two full-scale neighbours do not wrap
        // before the final reduction.
        if (config_i) begin
            bias = W1'(array_i_0) + W1'(array_i_1);
        end
        for (int k = 0; k < OUTPUT_NUM; k++) begin
            acc = '0;
            for (int j = 0; j < WEIGHT_NUM; j++) begin
                // Window k of group g starts at pixel g*OUTPUT_NUM + k.
                idx  = IXW'((int'(g) * OUTPUT_NUM + k + j) * W);
                px   = fmap_i[idx +: W];
                tap  = wht_i[j*W +: W];
                prod = (2*W)'(px) * (2*W)'(tap);
                acc  = acc + AW'(prod);
            end
`ifdef PE3X3_SAT_EN
            sum = (acc >>> FW) + AW'(bias);
            // In range when every bit from W-1 upward equals the sign.
            if ((&sum[AW-1:W-1]) || !(|sum[AW-1:W-1])) begin
                res_next[k*W +: W] = sum[W-1:0];
            end else if (sum[AW-1]) begin
                res_next[k*W +: W] = {1'b1, {(W-1){1'b0}}};
            end else begin
                res_next[k*W +: W] = {1'b0, {(W-1){1'b1}}};
            end
`else
            res_next[k*W +: W] = W'((acc >>> FW) + AW'(bias));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            g     <= '0;
            res_o <= '0;
        end else begin
            g     <= (g == GW'(NGRP - 1)) ? '0 : g + 1'b1;
            res_o <= res_next;
        end
    end

endmodule

// File: tb/tb_pe_3x3.sv
// Testbench for pe_3x3 at default parameters (56 pixels, 9 outputs, 3 taps,
// Q24.8).
//
// Each drive step pushes its expected res_o vector into exp_q. A monitor pops
// one entry shortly after every rising edge and compares it with res_o.
// Expected values come from hand-derived closed forms:
//   - ramp fmap[i] = i with weights {1,2,3}: result = 6*(b+k)+8
//   - ramp fmap[i] = i with weights {1,0,0}: result = b+k
//   - uniform constants
module tb_pe_3x3;

    localparam int W  = 32;
    localparam int NI = 56;
    localparam int NO = 9;
    localparam int NJ = 3;
    localparam int NG = 6;
    localparam int OW = NO * W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI*W-1:0]   fmap_i;
    logic [NJ*W-1:0]   wht_i;
    logic [W-1:0]      array_i_0;
    logic [W-1:0]      array_i_1;
    logic              config_i;
    logic [OW-1:0]     res_o;

    logic [OW-1:0]     exp_q[$];
    string             name_q[$];
    int                checks = 0;
    int                errors = 0;
    int                exp_g  = 0;

    pe_3x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fmap_i    (fmap_i),
        .wht_i     (wht_i),
        .array_i_0 (array_i_0),
        .array_i_1 (array_i_1),
        .config_i  (config_i),
        .res_o     (res_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // monitor + scoreboard
    always @(posedge clk) begin
        logic [OW-1:0] e;
        string         nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (res_o !== e) begin
                errors++;
                $display("FAIL %s: res_o=%h expected=%h", nm, res_o, e);
            end
        end
    end

    // expected-value helpers
    function automatic logic [OW-1:0] basic_vec(input int g, input logic [W-1:0] bias);
        logic [OW-1:0] v;
        for (int k = 0; k < NO; k++) v[k*W +: W] = W'((6 * (g * NO + k) + 8) << 8) + bias;
        return v;
    endfunction

    function automatic logic [OW-1:0] ramp1_vec(input int g);
        logic [OW-1:0] v;
        for (int k = 0; k < NO; k++) v[k*W +: W] = W'((g * NO + k) << 8);
        return v;
    endfunction

    function automatic logic [OW-1:0] uni_vec(input logic [W-1:0] val);
        logic [OW-1:0] v;
        for (int k = 0; k < NO; k++) v[k*W +: W] = val;
        return v;
    endfunction

    // driver tasks (called on a falling edge)
    task automatic set_ramp();
        for (int i = 0; i < NI; i++) fmap_i[i*W +: W] = W'(i << 8);
    endtask

    task automatic set_uniform(input logic [W-1:0] val);
        for (int i = 0; i < NI; i++) fmap_i[i*W +: W] = val;
    endtask

    task automatic set_wht(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
        wht_i = {w2, w1, w0};
    endtask

    task automatic step(input logic [OW-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        exp_g = (exp_g == NG - 1) ? 0 : exp_g + 1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b1;
        step('0, nm);
        rst_n = 1'b0;
        exp_g = 0;
    endtask

    task automatic run_basic(input int n, input logic [W-1:0] bias, input string nm);
        for (int i = 0; i < n; i++) step(basic_vec(exp_g, bias), $sformatf("%s_g%0d", nm, exp_g));
    endtask

    initial begin
        rst_n     = 1'b1;
        config_i  = 1'b0;
        array_i_0 = '0;
        array_i_1 = '0;
        set_ramp();
        set_wht(32'h100, 32'h200, 32'h300);
        @(negedge clk);

        // Reset, then a full row sweep plus the wrap back to group 0.
        do_reset("reset");
        run_basic(7, 32'h0, "basic");

        // Accumulate neighbour sums, then drop the bias again.
        config_i  = 1'b1;
        array_i_0 = 32'h100;
        array_i_1 = 32'h200;
        run_basic(3, 32'h300, "accum");
        config_i  = 1'b0;
        run_basic(1, 32'h0, "accum_off");

        // Mid-row reset after edge 3.
        do_reset("reset2");
        run_basic(3, 32'h0, "pre_rst");
        do_reset("midrow_reset");
        run_basic(1, 32'h0, "post_rst");

        // Weights change mid-row: new taps take effect on the next edge.
        set_wht(32'h100, 32'h0, 32'h0);
        step(ramp1_vec(exp_g), "wht_change_a");
        step(ramp1_vec(exp_g), "wht_change_b");

        // Negative operand, and truncation toward -inf.
        set_uniform(32'hFFFF_FE80);
        set_wht(32'h80, 32'h0, 32'h0);
        step(uni_vec(32'hFFFF_FF40), "neg_half");
        set_uniform(32'h80);
        set_wht(32'h1, 32'h0, 32'h0);
        step(uni_vec(32'h0), "trunc_pos");
        set_uniform(32'hFFFF_FF80);
        step(uni_vec(32'hFFFF_FFFF), "trunc_neg");

        // Product overflow: 3 * 2^30.
        set_uniform(32'h4000_0000);
        set_wht(32'h100, 32'h100, 32'h100);
`ifdef PE3X3_SAT_EN
        step(uni_vec(32'h7FFF_FFFF), "ovf_pos");
`else
        step(uni_vec(32'hC000_0000), "ovf_pos");
`endif

        // Bias overflow at both ends, with a zero convolution.
        set_uniform(32'h0);
        config_i  = 1'b1;
        array_i_0 = 32'h7FFF_FFFF;
        array_i_1 = 32'h7FFF_FFFF;
`ifdef PE3X3_SAT_EN
        step(uni_vec(32'h7FFF_FFFF), "bias_ovf_pos");
`else
        step(uni_vec(32'hFFFF_FFFE), "bias_ovf_pos");
`endif
        array_i_0 = 32'h8000_0000;
        array_i_1 = 32'h8000_0000;
`ifdef PE3X3_SAT_EN
        step(uni_vec(32'h8000_0000), "bias_ovf_neg");
`else
        step(uni_vec(32'h0000_0000), "bias_ovf_neg");
`endif
        config_i = 1'b0;
        step(uni_vec(32'h0), "bias_removed");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
